memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Responder end of the pipeline stage handshake (DIR/DOR/ack).
- Sits downstream of the instruction fetch stage and accepts an 8-bit address (PC) on data_in.
- Acknowledges the producer, reads an internal 256x8 instruction memory with fixed latency, then offers the opcode to the next stage on data_out/DOR and holds it until acknowledged.
- A side-load port fills the memory from the bench or a boot loader.

Parameters:
READ_LATENCY, 2, cycles from address acceptance to DOR rising; legal range 1..15.
DEPTH, 256, memory words; address is 8 bits and wraps modulo DEPTH.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low (0 = in reset); deassertion is synchronous to clk externally.
DIR  input  1  upstream data-input-ready (upstream DOR).
data_in  input  8  address from upstream, valid while DIR=1.
ack_prev  output  1  one-cycle pulse: address accepted.
DOR  output  1  data-output-ready to next stage.
data_out  output  8  opcode read from memory, stable while DOR=1.
ack_from_next  input  1  downstream accept pulse.
load_en  input  1  memory write strobe.
load_addr  input  8  memory write address.
load_data  input  8  memory write data.
reads_done  output  8  count of completed transfers, wraps 255->0.

Behaviour:
- Reset (reset=0, async): state=IDLE, ack_prev=0, DOR=0, data_out=0, reads_done=0, latency counter=0. Memory contents are not reset.
- Reset mid-transfer aborts the transfer; no ack or DOR is issued afterwards for it.
- States: IDLE, READ, RESPOND.
- IDLE:
  - On an edge with DIR=1: latch data_in as addr, ack_prev<=1 (exactly one cycle), cnt<=READ_LATENCY, go to READ.
  - Otherwise stay in IDLE with ack_prev<=0.
- READ:
  - ack_prev<=0; DIR is ignored.
  - This gives the required guard cycle: upstream drops DOR one edge after seeing the ack, so DIR is still 1 on the first READ edge.
  - Each edge decrements cnt. On the edge where cnt==1: data_out<=mem[addr], DOR<=1, go to RESPOND.
  - Latency: DIR sampled at edge E gives ack_prev high during E..E+1 and DOR high from edge E+READ_LATENCY.
- RESPOND:
  - Hold DOR=1 and data_out stable.
  - On an edge with ack_from_next=1: DOR<=0, reads_done<=reads_done+1 (mod 256), go to IDLE.
  - DIR is ignored in RESPOND; upstream must keep waiting. data_out keeps its last value after DOR falls.
- Back-to-back: the earliest next acceptance is the edge after returning to IDLE. Minimum period is READ_LATENCY+2 cycles per word.
- ack_from_next outside RESPOND is ignored.
- Memory write: on any edge with load_en=1, mem[load_addr]<=load_data, regardless of state.
  - If load_addr==addr and the write occurs at or before the sampling edge (cnt==1), data_out gets the new value on that edge only if the write happened on an earlier edge; a write on the sampling edge itself gives old data (read-before-write).
- Address wraps modulo 256; no out-of-range case exists at DEPTH=256.
- Display messages are permitted but not required; they have no functional effect.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, READ=2'd1, RESPOND=2'd2;
  - data width constant 8;
  - handshake signal naming common to all pipeline stages.
- One natural sub-module: imem_8x256, a synchronous-write/asynchronous-read memory array with the load port.
- The FSM, counter and handshake logic stay in memory_controller.

Test Plan:
1. Load mem[5]=8'hA7. Hold reset=0 for 3 cycles -> DOR=0, ack_prev=0, data_out=0, reads_done=0. Release, then DIR=1 with data_in=5 at edge E -> ack_prev high for exactly one cycle, DOR rises at E+2 with data_out=8'hA7.
2. Hold ack_from_next=0 for 10 cycles while in RESPOND, toggling DIR/data_in -> DOR and data_out=8'hA7 stay constant and no second ack_prev. Pulse ack_from_next -> DOR falls the next edge, reads_done=1.
3. Drive the fetch-stage protocol (DIR held one cycle past ack) with READ_LATENCY=1 -> exactly one ack_prev per address; addresses 0,1,2 with mem=10,11,12 -> outputs 10,11,12 in order, reads_done=3.
4. Assert reset asynchronously mid-READ (between edges) -> DOR, ack_prev and data_out go to 0 immediately; after release no DOR occurs until a new DIR.
5. During READ of address 9 (old 8'h00), write mem[9]=8'h3C one edge before the sampling edge -> data_out=8'h3C. Repeat with the write on the sampling edge -> data_out=8'h00.
6. Run 256 transfers -> reads_done wraps to 0. ack_from_next pulsed while in IDLE -> no counter change and no state change.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared definitions for the instruction-memory pipeline stage: widths, depth and FSM encodings.
// Every stage uses the same handshake names: DIR/data_in/ack_prev upstream, DOR/data_out/ack_from_next downstream.
package memory_controller_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/memory_controller_imem_8x256.sv
// 256x8 instruction store: synchronous write, asynchronous read; zero-cycle read latency.
// Has no flow control. The write port always succeeds, and a read on a write edge returns the old word.
module imem_8x256
  import memory_controller_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_controller.sv
// Responder stage that accepts a PC, reads the opcode after READ_LATENCY cycles and offers it downstream.
// The opcode is held on DOR until ack_from_next arrives. DIR is ignored until the stage returns to IDLE.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DIR,
  input  logic [ADDR_W-1:0] data_in,
  output logic              ack_prev,
  output logic              DOR,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_from_next,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [7:0]        reads_done
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic              ack_nx, dor_nx;
  logic [DATA_W-1:0] dout_nx, mem_rdata;
  logic [7:0]        reads_nx;

  imem_8x256 u_imem (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      ack_prev   <= 1'b0;
      DOR        <= 1'b0;
      data_out   <= '0;
      reads_done <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      addr       <= addr_nx;
      ack_prev   <= ack_nx;
      DOR        <= dor_nx;
      data_out   <= dout_nx;
      reads_done <= reads_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr;
    ack_nx   = 1'b0;
    dor_nx   = DOR;
    dout_nx  = data_out;
    reads_nx = reads_done;
    case (state)
      IDLE: begin
        if (DIR) begin
          addr_nx  = data_in;
          ack_nx   = 1'b1;
          cnt_nx   = CNT_W'(READ_LATENCY);
          state_nx = READ;
        end
      end
      // DIR is still high on the first READ edge; ignoring it here is the guard cycle.
      READ: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          dout_nx  = mem_rdata;
          dor_nx   = 1'b1;
          state_nx = RESPOND;
        end
      end
      RESPOND: begin
        if (ack_from_next) begin
          dor_nx   = 1'b0;
          reads_nx = reads_done + 8'd1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench: dut_a runs with READ_LATENCY=2 and dut_b with READ_LATENCY=1; both share reset and the load port.
module tb_memory_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [7:0] load_addr, load_data;

  logic       dir_a, ackp_a, dor_a, ackn_a;
  logic [7:0] din_a, dout_a, rd_a;
  logic       dir_b, ackp_b, dor_b, ackn_b;
  logic [7:0] din_b, dout_b, rd_b;

  int n_chk  = 0;
  int n_fail = 0;
  int acks_b = 0;

  always #5 clk = ~clk;

  memory_controller #(.READ_LATENCY(2)) dut_a (
    .clk(clk), .reset(rst_n), .DIR(dir_a), .data_in(din_a), .ack_prev(ackp_a),
    .DOR(dor_a), .data_out(dout_a), .ack_from_next(ackn_a), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .reads_done(rd_a)
  );

  memory_controller #(.READ_LATENCY(1)) dut_b (
    .clk(clk), .reset(rst_n), .DIR(dir_b), .data_in(din_b), .ack_prev(ackp_b),
    .DOR(dor_b), .data_out(dout_b), .ack_from_next(ackn_b), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .reads_done(rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    dir_a = 1'b0; din_a = '0; ackn_a = 1'b0;
    dir_b = 1'b0; din_b = '0; ackn_b = 1'b0;

    // 1: reset values, then first transfer with latency 2
    load(8'd5, 8'hA7);
    load(8'd0, 8'd10);
    load(8'd1, 8'd11);
    load(8'd2, 8'd12);
    load(8'd9, 8'h00);
    repeat (3) tick();
    chk("rst_dor", dor_a, 0);
    chk("rst_ack", ackp_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_reads", rd_a, 0);
    rst_n = 1'b1;
    tick();
    dir_a = 1'b1; din_a = 8'd5;
    tick();                                   // edge E
    chk("t1_ack_E", ackp_a, 1);
    chk("t1_dor_E", dor_a, 0);
    tick();                                   // E+1, DIR still high
    chk("t1_ack_E1", ackp_a, 0);
    chk("t1_dor_E1", dor_a, 0);
    dir_a = 1'b0;
    tick();                                   // E+2
    chk("t1_dor_E2", dor_a, 1);
    chk("t1_dout_E2", dout_a, 8'hA7);

    // 2: hold in RESPOND while upstream keeps requesting
    for (int i = 0; i < 10; i++) begin
      dir_a = i[0]; din_a = 8'(i * 7 + 3);
      tick();
      chk("t2_dor_hold", dor_a, 1);
      chk("t2_dout_hold", dout_a, 8'hA7);
      chk("t2_no_ack", ackp_a, 0);
    end
    dir_a = 1'b0; ackn_a = 1'b1;
    tick();
    ackn_a = 1'b0;
    chk("t2_dor_fall", dor_a, 0);
    chk("t2_reads", rd_a, 1);
    chk("t2_dout_kept", dout_a, 8'hA7);

    // 3: latency 1, fetch-stage protocol, three addresses
    for (int i = 0; i < 3; i++) begin
      dir_b = 1'b1; din_b = 8'(i);
      tick();
      if (ackp_b) acks_b++;
      chk("t3_ack_E", ackp_b, 1);
      tick();
      if (ackp_b) acks_b++;
      dir_b = 1'b0;
      chk("t3_dor", dor_b, 1);
      chk("t3_dout", dout_b, 32'(10 + i));
      ackn_b = 1'b1;
      tick();
      if (ackp_b) acks_b++;
      ackn_b = 1'b0;
      chk("t3_dor_fall", dor_b, 0);
    end
    chk("t3_ack_count", acks_b, 3);
    chk("t3_reads", rd_b, 3);

    // 4: asynchronous reset in the middle of READ
    dir_a = 1'b1; din_a = 8'd5;
    tick();
    dir_a = 1'b0;
    chk("t4_ack", ackp_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_dor_async", dor_a, 0);
    chk("t4_ack_async", ackp_a, 0);
    chk("t4_dout_async", dout_a, 0);
    chk("t4_reads_async", rd_a, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_dor", dor_a, 0);
      chk("t4_no_ack", ackp_a, 0);
    end

    // 5: write one edge before the sampling edge returns the new word
    dir_a = 1'b1; din_a = 8'd9;
    tick();
    dir_a = 1'b0;
    load_en = 1'b1; load_addr = 8'd9; load_data = 8'h3C;
    tick();
    load_en = 1'b0;
    tick();
    chk("t5_dor_early", dor_a, 1);
    chk("t5_dout_early", dout_a, 8'h3C);
    ackn_a = 1'b1;
    tick();
    ackn_a = 1'b0;
    load(8'd9, 8'h00);
    // same again, but the write lands on the sampling edge: old data is read
    dir_a = 1'b1; din_a = 8'd9;
    tick();
    dir_a = 1'b0;
    tick();
    load_en = 1'b1; load_addr = 8'd9; load_data = 8'h3C;
    tick();
    load_en = 1'b0;
    chk("t5_dor_same", dor_a, 1);
    chk("t5_dout_same", dout_a, 8'h00);
    ackn_a = 1'b1;
    tick();
    ackn_a = 1'b0;
    chk("t5_reads", rd_a, 2);

    // 6: wrap reads_done after 256 transfers, then an ack in IDLE is ignored
    for (int i = 0; i < 254; i++) begin
      dir_a = 1'b1; din_a = 8'(i);
      tick();
      dir_a = 1'b0;
      tick();
      tick();
      ackn_a = 1'b1;
      tick();
      ackn_a = 1'b0;
      if (i == 252) chk("t6_reads_255", rd_a, 255);
    end
    chk("t6_reads_wrap", rd_a, 0);
    ackn_a = 1'b1;
    tick();
    ackn_a = 1'b0;
    tick();
    chk("t6_idle_ack_reads", rd_a, 0);
    chk("t6_idle_ack_dor", dor_a, 0);
    dir_a = 1'b1; din_a = 8'd5;
    tick();
    dir_a = 1'b0;
    chk("t6_still_idle", ackp_a, 1);
    tick();
    tick();
    chk("t6_dout", dout_a, 8'hA7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
